// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn sequencer: validates moves, pulses the position decoder,
// keeps both boards, detects win/draw and alternates turns (optional idle forfeit).
module ttt_turn_ctrl #(
    parameter logic        FIRST_PLAYER   = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TO_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic [3:0] pos_code,
    output logic       pos_enable,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic       turn,
    output logic       move_ack,
    output logic       move_err,
    output logic       timeout,
    output logic [1:0] winner,
    output logic [8:0] win_line,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_CHECK = 3'd1,
        S_WRITE = 3'd2,
        S_EVAL  = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    localparam int unsigned    N_LINES = 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [8:0]      LINES [N_LINES] = '{
        9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054
    };

    // OR of every line fully covered by board b
    function automatic logic [8:0] line_union(input logic [8:0] b);
        logic [8:0] u;
        u = '0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            if ((b & LINES[i]) == LINES[i]) u = u | LINES[i];
        end
        return u;
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      pos_q, pos_d;
    logic [3:0]      pos_code_q, pos_code_d;
    logic [8:0]      board_x_q, board_x_d;
    logic [8:0]      board_o_q, board_o_d;
    logic            turn_q, turn_d;
    logic [1:0]      winner_q, winner_d;
    logic [8:0]      win_line_q, win_line_d;
    logic [3:0]      move_cnt_q, move_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            move_ready_q, move_ready_d;
    logic            pos_enable_q, pos_enable_d;
    logic            move_ack_q, move_ack_d;
    logic            move_err_q, move_err_d;
    logic            timeout_q, timeout_d;
    logic            game_over_q, game_over_d;

    logic [15:0]     occ_ext;
    logic [8:0]      cur_board;
    logic [8:0]      cur_lines;

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        pos_code_d   = pos_code_q;
        board_x_d    = board_x_q;
        board_o_d    = board_o_q;
        turn_d       = turn_q;
        winner_d     = winner_q;
        win_line_d   = win_line_q;
        move_cnt_d   = move_cnt_q;
        to_cnt_d     = '0;
        pos_enable_d = 1'b0;
        move_ack_d   = 1'b0;
        move_err_d   = 1'b0;
        timeout_d    = 1'b0;

        occ_ext   = {7'b0, board_x_q | board_o_q};
        cur_board = turn_q ? board_o_q : board_x_q;
        cur_lines = line_union(cur_board);

        case (state_q)
            S_WAIT: begin
                if (move_valid) begin
                    // legality is resolved here and held in move_err_q for CHECK
                    pos_d      = move_pos;
                    move_err_d = (move_pos > 4'd8) || occ_ext[move_pos];
                    state_d    = S_CHECK;
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    timeout_d = 1'b1;
                    turn_d    = ~turn_q;
                end else if (TO_EN) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_CHECK: begin
                if (move_err_q) begin
                    state_d = S_WAIT;
                end else begin
                    state_d      = S_WRITE;
                    pos_code_d   = pos_q;
                    pos_enable_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (turn_q) board_o_d = board_o_q | (9'b1 << pos_q);
                else        board_x_d = board_x_q | (9'b1 << pos_q);
                move_cnt_d = move_cnt_q + 4'd1;
                move_ack_d = 1'b1;
                state_d    = S_EVAL;
            end
            S_EVAL: begin
                if (|cur_lines) begin
                    winner_d   = turn_q ? 2'b10 : 2'b01;
                    win_line_d = cur_lines;
                    state_d    = S_OVER;
                end else if (move_cnt_q == 4'd9) begin
                    winner_d = 2'b11;
                    state_d  = S_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_WAIT;
                end
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_WAIT;
        endcase

        // new_game overrides everything, including an in-flight move
        if (new_game) begin
            state_d      = S_WAIT;
            pos_d        = '0;
            pos_code_d   = '0;
            board_x_d    = '0;
            board_o_d    = '0;
            turn_d       = FIRST_PLAYER;
            winner_d     = 2'b00;
            win_line_d   = '0;
            move_cnt_d   = '0;
            to_cnt_d     = '0;
            pos_enable_d = 1'b0;
            move_ack_d   = 1'b0;
            move_err_d   = 1'b0;
            timeout_d    = 1'b0;
        end

        move_ready_d = (state_d == S_WAIT);
        game_over_d  = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT;
            pos_q        <= '0;
            pos_code_q   <= '0;
            board_x_q    <= '0;
            board_o_q    <= '0;
            turn_q       <= FIRST_PLAYER;
            winner_q     <= 2'b00;
            win_line_q   <= '0;
            move_cnt_q   <= '0;
            to_cnt_q     <= '0;
            move_ready_q <= 1'b1;
            pos_enable_q <= 1'b0;
            move_ack_q   <= 1'b0;
            move_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            pos_code_q   <= pos_code_d;
            board_x_q    <= board_x_d;
            board_o_q    <= board_o_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            win_line_q   <= win_line_d;
            move_cnt_q   <= move_cnt_d;
            to_cnt_q     <= to_cnt_d;
            move_ready_q <= move_ready_d;
            pos_enable_q <= pos_enable_d;
            move_ack_q   <= move_ack_d;
            move_err_q   <= move_err_d;
            timeout_q    <= timeout_d;
            game_over_q  <= game_over_d;
        end
    end

    assign move_ready = move_ready_q;
    assign pos_code   = pos_code_q;
    assign pos_enable = pos_enable_q;
    assign board_x    = board_x_q;
    assign board_o    = board_o_q;
    assign turn       = turn_q;
    assign move_ack   = move_ack_q;
    assign move_err   = move_err_q;
    assign timeout    = timeout_q;
    assign winner     = winner_q;
    assign win_line   = win_line_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Scoreboard bench for ttt_turn_ctrl: stimulus queues expected pulses with their
// cycle; a negedge monitor pops and compares whenever the DUT pulses.
module tb_ttt_turn_ctrl;

    localparam int K_EN  = 0;
    localparam int K_ERR = 1;
    localparam int K_ACK = 2;
    localparam int K_TO  = 3;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic       move_ready;
    logic [3:0] pos_code;
    logic       pos_enable;
    logic [8:0] board_x;
    logic [8:0] board_o;
    logic       turn;
    logic       move_ack;
    logic       move_err;
    logic       timeout;
    logic [1:0] winner;
    logic [8:0] win_line;
    logic       game_over;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    ttt_turn_ctrl #(
        .FIRST_PLAYER  (1'b0),
        .TIMEOUT_CYCLES(5),
        .TO_W          (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .new_game  (new_game),
        .move_valid(move_valid),
        .move_pos  (move_pos),
        .move_ready(move_ready),
        .pos_code  (pos_code),
        .pos_enable(pos_enable),
        .board_x   (board_x),
        .board_o   (board_o),
        .turn      (turn),
        .move_ack  (move_ack),
        .move_err  (move_err),
        .timeout   (timeout),
        .winner    (winner),
        .win_line  (win_line),
        .game_over (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int data);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input int kind, input int data);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: kind %0d data %0d at cycle %0d, none expected",
                     kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                n_fail++;
                $display("FAIL pulse: got kind %0d cyc %0d data %0d expected kind %0d cyc %0d data %0d",
                         kind, cyc, data, e.kind, e.cyc, e.data);
            end
        end
    endtask

    // monitor: every pulse output must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (pos_enable) mon_check(K_EN, int'(pos_code));
            if (move_err)   mon_check(K_ERR, 0);
            if (move_ack)   mon_check(K_ACK, 0);
            if (timeout)    mon_check(K_TO, int'(turn));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_move(input logic [3:0] pos, input bit legal);
        int n;
        n = cyc;
        if (legal) begin
            push(K_EN, n + 2, int'(pos));
            push(K_ACK, n + 3, 0);
        end else begin
            push(K_ERR, n + 1, 0);
        end
        move_valid = 1'b1;
        move_pos   = pos;
        wait_cyc(1);
        move_valid = 1'b0;
        if (legal) wait_cyc(3);
        else       wait_cyc(1);
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        wait_cyc(1);
        new_game = 1'b0;
    endtask

    initial begin
        int n;
        int k;

        wait_cyc(2);
        chk("rst_move_ready", 32'(move_ready), 32'd1);
        chk("rst_turn",       32'(turn),       32'd0);
        chk("rst_board_x",    32'(board_x),    32'd0);
        chk("rst_board_o",    32'(board_o),    32'd0);
        chk("rst_winner",     32'(winner),     32'd0);
        chk("rst_game_over",  32'(game_over),  32'd0);
        chk("rst_pos_code",   32'(pos_code),   32'd0);
        rst_n = 1'b1;

        // X wins on the top row
        do_move(4'd0, 1'b1);
        do_move(4'd3, 1'b1);
        do_move(4'd1, 1'b1);
        do_move(4'd4, 1'b1);
        do_move(4'd2, 1'b1);
        chk("t1_winner",     32'(winner),     32'h1);
        chk("t1_win_line",   32'(win_line),   32'h007);
        chk("t1_game_over",  32'(game_over),  32'd1);
        chk("t1_board_x",    32'(board_x),    32'h007);
        chk("t1_board_o",    32'(board_o),    32'h018);
        chk("t1_move_ready", 32'(move_ready), 32'd0);
        move_valid = 1'b1;
        move_pos   = 4'd5;
        wait_cyc(4);
        move_valid = 1'b0;
        wait_cyc(1);
        chk("t1_over_hold",  32'(game_over),  32'd1);
        chk("t1_over_board", 32'(board_o),    32'h018);
        do_new_game();
        chk("ng_board_x",  32'(board_x),    32'd0);
        chk("ng_winner",   32'(winner),     32'd0);
        chk("ng_turn",     32'(turn),       32'd0);
        chk("ng_ready",    32'(move_ready), 32'd1);

        // occupied cell and out-of-range cell
        do_move(4'd4, 1'b1);
        do_move(4'd4, 1'b0);
        chk("t2_turn",    32'(turn),    32'd1);
        chk("t2_board_o", 32'(board_o), 32'd0);
        do_move(4'd9, 1'b0);
        chk("t2_turn_b",  32'(turn),    32'd1);
        do_new_game();

        // draw
        do_move(4'd4, 1'b1);
        do_move(4'd0, 1'b1);
        do_move(4'd2, 1'b1);
        do_move(4'd6, 1'b1);
        do_move(4'd3, 1'b1);
        do_move(4'd5, 1'b1);
        do_move(4'd7, 1'b1);
        do_move(4'd1, 1'b1);
        do_move(4'd8, 1'b1);
        chk("t3_winner",   32'(winner),            32'h3);
        chk("t3_win_line", 32'(win_line),          32'h0);
        chk("t3_full",     32'(board_x | board_o), 32'h1FF);
        chk("t3_board_x",  32'(board_x),           32'h19C);
        do_new_game();

        // idle forfeits, then a move on the expiry edge
        k = cyc;
        push(K_TO, k + 5, 1);
        push(K_TO, k + 10, 0);
        wait_cyc(5);
        chk("t4_turn_to1", 32'(turn), 32'd1);
        wait_cyc(5);
        chk("t4_turn_to2", 32'(turn), 32'd0);
        wait_cyc(4);
        do_move(4'd0, 1'b1);
        chk("t4_board_x", 32'(board_x), 32'h001);
        chk("t4_turn",    32'(turn),    32'd1);
        do_new_game();

        // new_game during WRITE discards the move
        do_move(4'd2, 1'b1);
        n = cyc;
        push(K_EN, n + 2, 7);
        move_valid = 1'b1;
        move_pos   = 4'd7;
        wait_cyc(1);
        move_valid = 1'b0;
        wait_cyc(1);
        new_game = 1'b1;
        wait_cyc(1);
        new_game = 1'b0;
        wait_cyc(1);
        chk("t5_board_o", 32'(board_o),    32'd0);
        chk("t5_board_x", 32'(board_x),    32'd0);
        chk("t5_turn",    32'(turn),       32'd0);
        chk("t5_ready",   32'(move_ready), 32'd1);

        // async reset in the middle of EVAL
        do_move(4'd0, 1'b1);
        n = cyc;
        push(K_EN, n + 2, 4);
        move_valid = 1'b1;
        move_pos   = 4'd4;
        wait_cyc(1);
        move_valid = 1'b0;
        wait_cyc(2);
        chk("t6_ack_pre",   32'(move_ack), 32'd1);
        chk("t6_board_pre", 32'(board_o),  32'h010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ack",     32'(move_ack),   32'd0);
        chk("t6_board_x", 32'(board_x),    32'd0);
        chk("t6_board_o", 32'(board_o),    32'd0);
        chk("t6_turn",    32'(turn),       32'd0);
        chk("t6_ready",   32'(move_ready), 32'd1);
        chk("t6_code",    32'(pos_code),   32'd0);
        wait_cyc(1);
        rst_n = 1'b1;
        do_move(4'd8, 1'b1);
        chk("t6_after", 32'(board_x), 32'h100);

        wait_cyc(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
